psum_bank_array: RTL and testbench
==================================

Name: psum_bank_array

Overview:
- Partial-sum storage and accumulate datapath; it is the memory-side responder to the psum bank manager.
- Consumes the manager's write bank/address, write_enable, read bank/address and read_bank_valid, together with array psum data.
- Performs write or read-add-write into SMALL/BIG banks.
- Provides a backpressured drain port so the controller can stream a finished bank out to the output buffer.

Parameters:
- SMALL_BANK_COUNT, 3, banks 0..2; depth SMALL_DEPTH.
- BIG_BANK_COUNT, 3, banks 3..5; depth 2**ADDR_WIDTH.
- TOTAL_BANK_COUNT, SMALL_BANK_COUNT+BIG_BANK_COUNT, total number of banks.
- BANK_INDEX_WIDTH, $clog2(TOTAL_BANK_COUNT), bank index width.
- ADDR_WIDTH, 8, address width (big depth 256).
- SMALL_DEPTH, 16, small bank depth.
- DATA_WIDTH, 24, signed psum width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- psum_in  in  DATA_WIDTH  signed psum from array, qualified by write_enable
- write_enable  in  1  accumulate request this cycle
- write_bank_index  in  BANK_INDEX_WIDTH  destination bank
- write_address  in  ADDR_WIDTH  destination address
- read_bank_valid  in  1  add the stored value at read bank/address to psum_in
- read_bank_index  in  BANK_INDEX_WIDTH  source bank for reduction
- read_address  in  ADDR_WIDTH  source address
- drain_start  in  1  one-cycle pulse to begin a drain
- drain_bank_index  in  BANK_INDEX_WIDTH  bank to drain
- drain_length  in  ADDR_WIDTH+1  words to drain from address 0; 0 means nothing to drain
- drain_data  out  DATA_WIDTH  drained word
- drain_valid  out  1  drain_data valid
- drain_ready  in  1  consumer accepts the word
- drain_last  out  1  final word of the drain
- drain_busy  out  1  drain in progress
- acc_busy  out  1  accumulate pipeline holds an in-flight write
- addr_error  out  1  sticky flag: an out-of-range bank or address was seen

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset values: all outputs 0; pipeline valid bits cleared; drain FSM goes to D_IDLE; output FIFO emptied.
- Memory contents are not reset.
- Each bank is modelled as 1 read port plus 1 write port, with registered (synchronous) read that returns the old data on same-cycle read/write.
- Accumulate pipeline, fixed latency of 2 cycles:
  - Cycle T (S0): write_enable is sampled. If read_bank_valid, a read is issued to read_bank_index/read_address. psum_in, write bank/address and the read flag are registered.
  - Cycle T+1 (S1): sum = rd_data + psum_d when the read flag is set, otherwise psum_d alone. The write commits at the end of T+1. The value is readable from T+2.
- Addition is signed and saturating to DATA_WIDTH: clamps at +2^(DATA_WIDTH-1)-1 and -2^(DATA_WIDTH-1).
- Forwarding: if the S0 read matches the S1 write (same bank and address), rd_data is replaced by the S1 sum. Back-to-back accumulation into one location is therefore exact.
- read_bank_valid without write_enable is ignored.
- Range checks:
  - A bank index >= TOTAL_BANK_COUNT, or an address >= SMALL_DEPTH on a small bank, suppresses that write, or treats that read as 0.
  - Either case sets addr_error, which is cleared only by reset.
- acc_busy = S0 or S1 valid.
- Drain FSM states:
  - D_IDLE: drain_start with drain_length > 0 latches bank and length and sets the address counter to 0, then goes to D_RUN. drain_start with drain_length = 0 stays in D_IDLE with no output. drain_start outside D_IDLE is ignored.
  - D_RUN: issues one read per cycle when (FIFO occupancy + reads in flight) < 2 and the accumulate S0 is not reading the same bank. Accumulate always has priority. When the final read is issued, go to D_FLUSH.
  - D_FLUSH: wait until the FIFO is empty and the last word has been accepted, then return to D_IDLE.
- Drain output buffering:
  - A 2-entry output FIFO holds read data, so drain_valid/drain_data stay stable while drain_ready is low.
  - A word transfers when drain_valid and drain_ready are both high.
  - drain_last is asserted with the word at address drain_length-1.
- drain_busy is high in D_RUN and D_FLUSH.
- The drain does not modify memory.
- Concurrent accumulate writes to the bank being drained are legal. Drained data reflects memory state at the read-issue cycle, and forwarding applies.
- Reset mid-drain or mid-accumulate drops all in-flight operations. A partially committed bank keeps whatever words were already written.

Decomposition:
- Shared package psum_pkg holds:
  - the bank-count, depth and width constants;
  - the drain state enum (D_IDLE, D_RUN, D_FLUSH);
  - the function is_small_bank(idx);
  - the function addr_in_range(idx, addr).
- One natural sub-module, psum_bank_ram: a single bank with parameterised depth, 1R1W, registered read. It is instantiated TOTAL_BANK_COUNT times, with generate selecting the depth per bank.

Test Plan:
- Plain write: write_enable, bank 3, addr 0..9, psum_in = 100+addr, read_bank_valid = 0; then drain bank 3, length 10 → drain_data 100..109, drain_last on the 10th word.
- Reduction: bank 0 holds 5 at addr 0..3; write_enable with read bank 0 → write bank 1, psum_in = 7 → drain bank 1 yields 12,12,12,12.
- Forwarding: 4 consecutive cycles with read = write = bank 4 addr 2, psum_in = 1, initial value 0 → memory value 4; no cycle is lost.
- Saturation, DATA_WIDTH = 24: stored 8388600 + psum_in 100 → 8388607; stored -8388600 + psum_in -100 → -8388608.
- Backpressure: drain bank 5, length 6, with drain_ready toggling 1,0,0,1 → data held stable while not ready, 6 words in order, drain_busy falls 1 cycle after the last handshake.
- Errors and reset: write to bank 1 addr 20 → no write, addr_error = 1. drain_length = 0 → no drain_valid. Assert reset mid-drain → drain_valid = 0 and drain_busy = 0 next cycle.

Source files
------------

// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared constants, drain states and range/saturation helpers
package psum_pkg;
  localparam int SMALL_BANK_COUNT = 3;
  localparam int BIG_BANK_COUNT   = 3;
  localparam int TOTAL_BANK_COUNT = SMALL_BANK_COUNT + BIG_BANK_COUNT;
  localparam int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT);
  localparam int ADDR_WIDTH       = 8;
  localparam int SMALL_DEPTH      = 16;
  localparam int BIG_DEPTH        = 1 << ADDR_WIDTH;
  localparam int DATA_WIDTH       = 24;
  localparam int LEN_WIDTH        = ADDR_WIDTH + 1;

  localparam logic [1:0] D_IDLE  = 2'd0;
  localparam logic [1:0] D_RUN   = 2'd1;
  localparam logic [1:0] D_FLUSH = 2'd2;

  function automatic logic is_small_bank(input logic [BANK_INDEX_WIDTH-1:0] idx);
    return idx < BANK_INDEX_WIDTH'(SMALL_BANK_COUNT);
  endfunction

  function automatic logic addr_in_range(input logic [BANK_INDEX_WIDTH-1:0] idx,
                                         input logic [ADDR_WIDTH-1:0] addr);
    return (idx < BANK_INDEX_WIDTH'(TOTAL_BANK_COUNT)) &&
           (!is_small_bank(idx) || (addr < ADDR_WIDTH'(SMALL_DEPTH)));
  endfunction

  // Signed add clamped to the DATA_WIDTH range
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s[DATA_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/psum_bank_ram.sv
// rtl/psum_bank_ram.sv - single 1R1W psum bank with registered read
module psum_bank_ram
  import psum_pkg::*;
#(
  parameter int DEPTH = SMALL_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  // Write port plus registered read; a same-cycle collision returns the old word
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/psum_bank_array.sv
// rtl/psum_bank_array.sv - psum banks with 2-cycle accumulate pipeline and drain port
module psum_bank_array
  import psum_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       psum_in,
  input  logic                        write_enable,
  input  logic [BANK_INDEX_WIDTH-1:0] write_bank_index,
  input  logic [ADDR_WIDTH-1:0]       write_address,
  input  logic                        read_bank_valid,
  input  logic [BANK_INDEX_WIDTH-1:0] read_bank_index,
  input  logic [ADDR_WIDTH-1:0]       read_address,
  input  logic                        drain_start,
  input  logic [BANK_INDEX_WIDTH-1:0] drain_bank_index,
  input  logic [LEN_WIDTH-1:0]        drain_length,
  output logic [DATA_WIDTH-1:0]       drain_data,
  output logic                        drain_valid,
  input  logic                        drain_ready,
  output logic                        drain_last,
  output logic                        drain_busy,
  output logic                        acc_busy,
  output logic                        addr_error
);
  logic [DATA_WIDTH-1:0] bank_rd_data [TOTAL_BANK_COUNT];

  logic s1_valid_q, s1_valid_d, s1_wr_ok_q, s1_wr_ok_d;
  logic s1_rd_q, s1_rd_d, s1_fwd_q, s1_fwd_d;
  logic [BANK_INDEX_WIDTH-1:0] s1_wbank_q, s1_wbank_d, s1_rbank_q, s1_rbank_d;
  logic [ADDR_WIDTH-1:0] s1_waddr_q, s1_waddr_d;
  logic [DATA_WIDTH-1:0] s1_psum_q, s1_psum_d, fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] s1_operand, s1_sum;
  logic wr_ok, rd_req, rd_ok, acc_rd, s1_commit;

  logic [1:0] d_state_q, d_state_d;
  logic [BANK_INDEX_WIDTH-1:0] d_bank_q, d_bank_d;
  logic [LEN_WIDTH-1:0] d_len_q, d_len_d, d_addr_q, d_addr_d;
  logic d_infl_q, d_infl_d, d_infl_ok_q, d_infl_ok_d;
  logic d_infl_fwd_q, d_infl_fwd_d, d_infl_last_q, d_infl_last_d;
  logic drn_issue, drn_ok, drn_rd, drn_fwd, drn_is_last;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [DATA_WIDTH-1:0] fifo_data_d [2];
  logic fifo_last_q [2];
  logic fifo_last_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] fifo_cnt_q, fifo_cnt_d;
  logic push, pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic addr_error_q, addr_error_d;

  // Accumulate S0 decode, S1 sum and forwarding of the in-flight write into the next read
  always_comb begin
    wr_ok      = addr_in_range(write_bank_index, write_address);
    rd_req     = write_enable && read_bank_valid;
    rd_ok      = addr_in_range(read_bank_index, read_address);
    acc_rd     = rd_req && rd_ok;
    s1_commit  = s1_valid_q && s1_wr_ok_q;
    s1_operand = '0;
    if (s1_rd_q) s1_operand = s1_fwd_q ? fwd_data_q : bank_rd_data[s1_rbank_q];
    s1_sum     = sat_add(s1_operand, s1_psum_q);
    s1_valid_d = write_enable;
    s1_wr_ok_d = wr_ok;
    s1_rd_d    = acc_rd;
    s1_fwd_d   = s1_commit && (s1_wbank_q == read_bank_index) && (s1_waddr_q == read_address);
    s1_wbank_d = write_bank_index;
    s1_waddr_d = write_address;
    s1_rbank_d = read_bank_index;
    s1_psum_d  = psum_in;
    fwd_data_d = s1_sum;
  end

  // Drain FSM: one read per cycle while the FIFO has room, yielding to accumulate reads
  always_comb begin
    drn_is_last   = (d_addr_q == d_len_q - LEN_WIDTH'(1));
    drn_issue     = (d_state_q == D_RUN) && ((fifo_cnt_q + {1'b0, d_infl_q}) < 2'd2) &&
                    !(acc_rd && (read_bank_index == d_bank_q));
    drn_ok        = addr_in_range(d_bank_q, d_addr_q[ADDR_WIDTH-1:0]);
    drn_rd        = drn_issue && drn_ok;
    drn_fwd       = s1_commit && (s1_wbank_q == d_bank_q) &&
                    (s1_waddr_q == d_addr_q[ADDR_WIDTH-1:0]);
    d_state_d     = d_state_q;
    d_bank_d      = d_bank_q;
    d_len_d       = d_len_q;
    d_addr_d      = d_addr_q;
    d_infl_d      = drn_issue;
    d_infl_ok_d   = drn_ok;
    d_infl_fwd_d  = drn_fwd;
    d_infl_last_d = drn_is_last;
    case (d_state_q)
      D_IDLE: begin
        if (drain_start && (drain_length != '0)) begin
          d_bank_d  = drain_bank_index;
          d_len_d   = drain_length;
          d_addr_d  = '0;
          d_state_d = D_RUN;
        end
      end
      D_RUN: begin
        if (drn_issue) begin
          d_addr_d = d_addr_q + LEN_WIDTH'(1);
          if (drn_is_last) d_state_d = D_FLUSH;
        end
      end
      D_FLUSH: begin
        if (!d_infl_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop)))
          d_state_d = D_IDLE;
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  // Output FIFO bookkeeping and the sticky range-error flag
  always_comb begin
    pop         = (fifo_cnt_q != 2'd0) && drain_ready;
    push        = d_infl_q;
    push_data   = d_infl_fwd_q ? fwd_data_q : (d_infl_ok_q ? bank_rd_data[d_bank_q] : '0);
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = push_data;
      fifo_last_d[wr_ptr_q] = d_infl_last_q;
    end
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    fifo_cnt_d   = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    addr_error_d = addr_error_q || (write_enable && !wr_ok) || (rd_req && !rd_ok) ||
                   (drn_issue && !drn_ok);
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      d_state_q    <= D_IDLE;
      d_infl_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fifo_cnt_q   <= 2'd0;
      addr_error_q <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      d_state_q    <= d_state_d;
      d_infl_q     <= d_infl_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      addr_error_q <= addr_error_d;
    end
  end

  // Datapath registers, always qualified by a reset control bit
  always_ff @(posedge clk) begin
    s1_wr_ok_q    <= s1_wr_ok_d;
    s1_rd_q       <= s1_rd_d;
    s1_fwd_q      <= s1_fwd_d;
    s1_wbank_q    <= s1_wbank_d;
    s1_waddr_q    <= s1_waddr_d;
    s1_rbank_q    <= s1_rbank_d;
    s1_psum_q     <= s1_psum_d;
    fwd_data_q    <= fwd_data_d;
    d_bank_q      <= d_bank_d;
    d_len_q       <= d_len_d;
    d_addr_q      <= d_addr_d;
    d_infl_ok_q   <= d_infl_ok_d;
    d_infl_fwd_q  <= d_infl_fwd_d;
    d_infl_last_q <= d_infl_last_d;
    fifo_data_q   <= fifo_data_d;
    fifo_last_q   <= fifo_last_d;
  end

  for (genvar b = 0; b < TOTAL_BANK_COUNT; b++) begin : g_bank
    localparam int DEPTH = (b < SMALL_BANK_COUNT) ? SMALL_DEPTH : BIG_DEPTH;
    localparam int RAW   = $clog2(DEPTH);
    logic sel_acc, sel_drn;
    assign sel_acc = acc_rd && (read_bank_index == BANK_INDEX_WIDTH'(b));
    assign sel_drn = drn_rd && (d_bank_q == BANK_INDEX_WIDTH'(b));
    psum_bank_ram #(.DEPTH(DEPTH), .AW(RAW), .DW(DATA_WIDTH)) u_ram (
      .clk     (clk),
      .rd_en   (sel_acc || sel_drn),
      .rd_addr (sel_acc ? read_address[RAW-1:0] : d_addr_q[RAW-1:0]),
      .rd_data (bank_rd_data[b]),
      .wr_en   (s1_commit && (s1_wbank_q == BANK_INDEX_WIDTH'(b))),
      .wr_addr (s1_waddr_q[RAW-1:0]),
      .wr_data (s1_sum)
    );
  end

  assign drain_valid = (fifo_cnt_q != 2'd0);
  assign drain_data  = drain_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign drain_last  = drain_valid && fifo_last_q[rd_ptr_q];
  assign drain_busy  = (d_state_q != D_IDLE);
  assign acc_busy    = write_enable || s1_valid_q;
  assign addr_error  = addr_error_q;
endmodule

// File: tb/tb_psum_bank_array.sv
// tb/tb_psum_bank_array.sv - self-checking bench with a sequential memory model
module tb_psum_bank_array;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] psum_in;
  logic          write_enable;
  logic [2:0]    write_bank_index;
  logic [7:0]    write_address;
  logic          read_bank_valid;
  logic [2:0]    read_bank_index;
  logic [7:0]    read_address;
  logic          drain_start;
  logic [2:0]    drain_bank_index;
  logic [8:0]    drain_length;
  logic [DW-1:0] drain_data;
  logic          drain_valid;
  logic          drain_ready;
  logic          drain_last;
  logic          drain_busy;
  logic          acc_busy;
  logic          addr_error;

  psum_bank_array dut (
    .clk(clk), .reset(reset), .psum_in(psum_in), .write_enable(write_enable),
    .write_bank_index(write_bank_index), .write_address(write_address),
    .read_bank_valid(read_bank_valid), .read_bank_index(read_bank_index),
    .read_address(read_address), .drain_start(drain_start),
    .drain_bank_index(drain_bank_index), .drain_length(drain_length),
    .drain_data(drain_data), .drain_valid(drain_valid), .drain_ready(drain_ready),
    .drain_last(drain_last), .drain_busy(drain_busy), .acc_busy(acc_busy),
    .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int model [6][256];
  int got_data [$];
  bit got_last [$];
  int hold_viol;
  bit busy_at_last, busy_after, drain_to;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_range(input int b, input int a);
    return (b >= 0) && (b < 6) && ((b >= 3) || (a < 16));
  endfunction

  function automatic int sat24(input longint v);
    if (v > 64'sd8388607) return 8388607;
    if (v < -64'sd8388608) return -8388608;
    return int'(v);
  endfunction

  // One accumulate request; the model applies requests in issue order
  task automatic acc(input int wb, input int wa, input bit rv, input int rb, input int ra,
                     input int p);
    longint s;
    write_enable = 1'b1;
    write_bank_index = wb[2:0];
    write_address = wa[7:0];
    read_bank_valid = rv;
    read_bank_index = rb[2:0];
    read_address = ra[7:0];
    psum_in = p[DW-1:0];
    s = p;
    if (rv && in_range(rb, ra)) s = s + model[rb][ra];
    if (in_range(wb, wa)) model[wb][wa] = sat24(s);
    tick();
  endtask

  task automatic idle(input int n);
    write_enable = 1'b0;
    read_bank_valid = 1'b0;
    repeat (n) tick();
  endtask

  // Runs a drain; mode 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready
  task automatic drain_run(input int bank, input int len, input int mode);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int cyc;
    bit held;
    logic [DW-1:0] held_data;
    got_data.delete();
    got_last.delete();
    hold_viol = 0;
    busy_at_last = 1'b0;
    cyc = 0;
    held = 1'b0;
    held_data = '0;
    drain_bank_index = bank[2:0];
    drain_length = len[8:0];
    drain_start = 1'b1;
    drain_ready = 1'b0;
    tick();
    drain_start = 1'b0;
    while (got_data.size() < len && cyc < 400) begin
      case (mode)
        0: drain_ready = 1'b1;
        1: drain_ready = pat[cyc % 4];
        default: drain_ready = 1'($urandom_range(0, 1));
      endcase
      if (held && (drain_valid !== 1'b1 || drain_data !== held_data)) hold_viol++;
      held = 1'b0;
      if (drain_valid === 1'b1 && drain_ready) begin
        got_data.push_back(int'($signed(drain_data)));
        got_last.push_back(drain_last);
        busy_at_last = drain_busy;
      end else if (drain_valid === 1'b1) begin
        held = 1'b1;
        held_data = drain_data;
      end
      tick();
      cyc++;
    end
    drain_ready = 1'b0;
    busy_after = drain_busy;
    drain_to = (got_data.size() < len);
  endtask

  task automatic test_reset();
    checks++;
    if ({drain_valid, drain_last, drain_busy, acc_busy, addr_error} !== 5'b0 || drain_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b db=%b ab=%b e=%b d=%0d, expected all 0",
               drain_valid, drain_last, drain_busy, acc_busy, addr_error, drain_data);
    end
  endtask

  task automatic test_plain_write();
    for (int a = 0; a < 10; a++) acc(3, a, 1'b0, 0, 0, 100 + a);
    idle(2);
    drain_run(3, 10, 0);
    checks++;
    if (drain_to) begin errors++; $display("FAIL plain_timeout: got %0d words, expected 10", got_data.size()); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 100 + i || got_last[i] !== (i == 9)) begin
        errors++;
        $display("FAIL plain_word[%0d]: got %0d last %0b, expected %0d last %0b",
                 i, got_data[i], got_last[i], 100 + i, i == 9);
      end
    end
  endtask

  task automatic test_reduction();
    for (int a = 0; a < 4; a++) acc(0, a, 1'b0, 0, 0, 5);
    for (int a = 0; a < 4; a++) acc(1, a, 1'b1, 0, a, 7);
    idle(2);
    drain_run(1, 4, 0);
    checks++;
    if (drain_to) begin errors++; $display("FAIL reduce_timeout: got %0d words, expected 4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 12 || got_data[i] !== model[1][i]) begin
        errors++;
        $display("FAIL reduce_word[%0d]: got %0d, expected 12", i, got_data[i]);
      end
    end
  endtask

  task automatic test_forwarding();
    for (int a = 0; a < 3; a++) acc(4, a, 1'b0, 0, 0, 0);
    for (int k = 0; k < 4; k++) acc(4, 2, 1'b1, 4, 2, 1);
    idle(0);
    checks++;
    if (acc_busy !== 1'b1) begin errors++; $display("FAIL fwd_busy_s1: got %b, expected 1", acc_busy); end
    tick();
    checks++;
    if (acc_busy !== 1'b0) begin errors++; $display("FAIL fwd_busy_done: got %b, expected 0", acc_busy); end
    drain_run(4, 3, 0);
    checks++;
    if (drain_to || got_data[2] !== 4 || got_data[0] !== 0) begin
      errors++;
      $display("FAIL fwd_value: got %0d (addr0 %0d), expected 4 (addr0 0)", got_data[2], got_data[0]);
    end
  endtask

  task automatic test_saturation();
    acc(3, 10, 1'b0, 0, 0, 8388600);
    acc(3, 10, 1'b1, 3, 10, 100);
    acc(3, 11, 1'b0, 0, 0, -8388600);
    acc(3, 11, 1'b1, 3, 11, -100);
    idle(2);
    drain_run(3, 12, 0);
    checks++;
    if (drain_to || got_data[10] !== 8388607) begin
      errors++;
      $display("FAIL sat_pos: got %0d, expected 8388607", got_data[10]);
    end
    checks++;
    if (drain_to || got_data[11] !== -8388608 || got_last[11] !== 1'b1) begin
      errors++;
      $display("FAIL sat_neg: got %0d last %0b, expected -8388608 last 1", got_data[11], got_last[11]);
    end
  endtask

  task automatic test_backpressure();
    for (int a = 0; a < 6; a++) acc(5, a, 1'b0, 0, 0, int'($urandom_range(0, 200000)) - 100000);
    idle(2);
    drain_run(5, 6, 1);
    checks++;
    if (drain_to) begin errors++; $display("FAIL bp_timeout: got %0d words, expected 6", got_data.size()); end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles, expected 0", hold_viol); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== model[5][i] || got_last[i] !== (i == 5)) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %0d last %0b, expected %0d last %0b",
                 i, got_data[i], got_last[i], model[5][i], i == 5);
      end
    end
    checks++;
    if (busy_at_last !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL bp_busy: got at_last=%b after=%b, expected 1 then 0", busy_at_last, busy_after);
    end
  endtask

  task automatic test_random();
    int pb, pa;
    for (int b = 0; b < 6; b++)
      for (int a = 0; a < 16; a++) acc(b, a, 1'b0, 0, 0, int'($urandom_range(0, 8388607)) - 4194304);
    pb = 0;
    pa = 0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        write_enable = 1'b0;
        read_bank_valid = 1'($urandom_range(0, 1));
        tick();
      end else begin
        int wb, wa, rb, ra, p;
        wb = $urandom_range(0, 5);
        wa = $urandom_range(0, 15);
        if ($urandom_range(0, 2) == 0) begin rb = pb; ra = pa; end
        else begin rb = $urandom_range(0, 5); ra = $urandom_range(0, 15); end
        p = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 16777215)) - 8388608
                                        : int'($urandom_range(0, 2000)) - 1000;
        acc(wb, wa, 1'($urandom_range(0, 3) != 0), rb, ra, p);
        pb = wb;
        pa = wa;
      end
    end
    idle(2);
    for (int b = 0; b < 6; b++) begin
      drain_run(b, 16, 2);
      checks++;
      if (drain_to || hold_viol !== 0) begin
        errors++;
        $display("FAIL rand_drain[%0d]: got %0d words %0d unstable, expected 16 words 0 unstable",
                 b, got_data.size(), hold_viol);
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (i >= got_data.size() || got_data[i] !== model[b][i] || got_last[i] !== (i == 15)) begin
          errors++;
          $display("FAIL rand_word[%0d][%0d]: got %0d, expected %0d", b, i, got_data[i], model[b][i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    checks++;
    if (addr_error !== 1'b0) begin errors++; $display("FAIL err_clean: got %b, expected 0", addr_error); end
    acc(1, 4, 1'b0, 0, 0, 77);
    acc(1, 20, 1'b0, 0, 0, 999);
    acc(2, 0, 1'b1, 1, 30, 55);
    idle(2);
    checks++;
    if (addr_error !== 1'b1) begin errors++; $display("FAIL err_flag: got %b, expected 1", addr_error); end
    drain_run(1, 5, 0);
    checks++;
    if (drain_to || got_data[4] !== 77 || got_data[4] !== model[1][4]) begin
      errors++;
      $display("FAIL err_suppress: got %0d, expected 77", got_data[4]);
    end
    drain_run(2, 1, 0);
    checks++;
    if (drain_to || got_data[0] !== 55) begin
      errors++;
      $display("FAIL err_read_zero: got %0d, expected 55", got_data[0]);
    end
    drain_bank_index = 3'd3;
    drain_length = 9'd0;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (drain_valid !== 1'b0 || drain_busy !== 1'b0) begin
        errors++;
        $display("FAIL zero_len[%0d]: got v=%b busy=%b, expected 0 0", k, drain_valid, drain_busy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    drain_bank_index = 3'd5;
    drain_length = 9'd6;
    drain_ready = 1'b0;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    repeat (5) tick();
    checks++;
    if (drain_valid !== 1'b1 || drain_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_drain_active: got v=%b busy=%b, expected 1 1", drain_valid, drain_busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (drain_valid !== 1'b0 || drain_busy !== 1'b0 || addr_error !== 1'b0 || drain_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain_reset: got v=%b busy=%b err=%b last=%b, expected 0 0 0 0",
               drain_valid, drain_busy, addr_error, drain_last);
    end
    drain_run(5, 6, 0);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== model[5][i]) begin
        errors++;
        $display("FAIL post_reset_word[%0d]: got %0d, expected %0d", i, got_data[i], model[5][i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    psum_in = '0;
    write_enable = 1'b0;
    write_bank_index = '0;
    write_address = '0;
    read_bank_valid = 1'b0;
    read_bank_index = '0;
    read_address = '0;
    drain_start = 1'b0;
    drain_bank_index = '0;
    drain_length = '0;
    drain_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    test_reset();
    test_plain_write();
    test_reduction();
    test_forwarding();
    test_saturation();
    test_backpressure();
    test_random();
    test_errors();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
